// File: rtl/tapped_shift_register_array.sv
// Bidirectional DEPTH x BIT_WIDTH delay line with a run-time output tap, per-stage valid tags and occupancy count.
// Define SHIFT_ARRAY_OUT_REG_EN to register out/out_valid (one extra cycle of latency).
module tapped_shift_register_array #(
   parameter int BIT_WIDTH   = 8,
   parameter int DEPTH       = 8,
   parameter int TAP_WIDTH   = 3,
   parameter int COUNT_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   dir,
   input  logic                   flush,
   input  logic [BIT_WIDTH-1:0]   in,
   input  logic                   in_valid,
   input  logic [TAP_WIDTH-1:0]   tap,
   output logic [BIT_WIDTH-1:0]   out,
   output logic                   out_valid,
   output logic [COUNT_WIDTH-1:0] fill_count
);

   // enable advances the array by one stage per rising edge; flush wins over enable.
   localparam logic [TAP_WIDTH:0] MAX_TAP = (TAP_WIDTH + 1)'(DEPTH - 1);

   logic [BIT_WIDTH-1:0]   s [DEPTH];
   logic [DEPTH-1:0]       v;
   logic [COUNT_WIDTH-1:0] count;
   logic                   drop;
   logic [TAP_WIDTH:0]     tap_eff;
   logic [TAP_WIDTH:0]     sel;
   logic [BIT_WIDTH-1:0]   mux_data;
   logic                   mux_valid;

   // The stage leaving the array is the far end for the current direction.
   assign drop = dir ? v[0] : v[DEPTH-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) s[i] <= '0;
         v     <= '0;
         count <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) s[i] <= '0;
         v     <= '0;
         count <= '0;
      end else if (enable) begin
         if (!dir) begin
            s[0] <= in;
            for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
            v <= {v[DEPTH-2:0], in_valid};
         end else begin
            s[DEPTH-1] <= in;
            for (int i = 0; i < DEPTH - 1; i++) s[i] <= s[i+1];
            v <= {in_valid, v[DEPTH-1:1]};
         end
         count <= count + COUNT_WIDTH'(in_valid) - COUNT_WIDTH'(drop);
      end
   end

   // Tap counts from the entry point, so right mode mirrors the stage index.
   always_comb begin
      tap_eff   = ({1'b0, tap} > MAX_TAP) ? MAX_TAP : {1'b0, tap};
      sel       = dir ? (MAX_TAP - tap_eff) : tap_eff;
      mux_data  = '0;
      mux_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel == (TAP_WIDTH + 1)'(i)) begin
            mux_data  = s[i];
            mux_valid = v[i];
         end
      end
   end

`ifdef SHIFT_ARRAY_OUT_REG_EN
   logic [BIT_WIDTH-1:0] out_q;
   logic                 out_valid_q;

   // Loaded every edge regardless of enable so tap/dir changes land one edge later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= mux_data;
         out_valid_q <= mux_valid;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
`else
   assign out       = mux_data;
   assign out_valid = mux_valid;
`endif

   assign fill_count = count;

endmodule

// File: tb/tb_tapped_shift_register_array.sv
// Bench for tapped_shift_register_array: an 8-deep and a 6-deep instance share stimulus and are
// checked against array-of-stages reference models (handles SHIFT_ARRAY_OUT_REG_EN too).
module tb_tapped_shift_register_array;

   localparam int BW = 8;
`ifdef SHIFT_ARRAY_OUT_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   typedef struct packed {
      logic [BW-1:0] d;
      logic          v;
   } stage_t;

   // ---------------- clock / reset / stimulus signals ----------------
   logic          clk      = 1'b0;
   logic          reset    = 1'b0;
   logic          enable   = 1'b0;
   logic          dir      = 1'b0;
   logic          flush    = 1'b0;
   logic          in_valid = 1'b0;
   logic [BW-1:0] in_w     = '0;
   logic [2:0]    tap      = '0;

   logic [BW-1:0] out_a, out_b;
   logic          ov_a, ov_b;
   logic [3:0]    fc_a;
   logic [2:0]    fc_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tapped_shift_register_array #(
      .BIT_WIDTH(8), .DEPTH(8), .TAP_WIDTH(3), .COUNT_WIDTH(4)
   ) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .flush(flush),
      .in(in_w), .in_valid(in_valid), .tap(tap),
      .out(out_a), .out_valid(ov_a), .fill_count(fc_a)
   );

   tapped_shift_register_array #(
      .BIT_WIDTH(8), .DEPTH(6), .TAP_WIDTH(3), .COUNT_WIDTH(3)
   ) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .dir(dir), .flush(flush),
      .in(in_w), .in_valid(in_valid), .tap(tap),
      .out(out_b), .out_valid(ov_b), .fill_count(fc_b)
   );

   // ---------------- reference model ----------------
   stage_t mdl [2][8];
   stage_t oreg [2];
   int     dep [2] = '{8, 6};

   function automatic stage_t mux(int k);
      int t;
      int idx;
      t   = (int'(tap) > dep[k] - 1) ? dep[k] - 1 : int'(tap);
      idx = dir ? dep[k] - 1 - t : t;
      return mdl[k][idx];
   endfunction

   function automatic stage_t exp_stage(int k);
`ifdef SHIFT_ARRAY_OUT_REG_EN
      return oreg[k];
`else
      return mux(k);
`endif
   endfunction

   function automatic int exp_cnt(int k);
      int c;
      c = 0;
      for (int i = 0; i < dep[k]; i++) c += int'(mdl[k][i].v);
      return c;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) mdl[k][i] = '0;
         oreg[k] = '0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         stage_t nw;
         nw.d    = in_w;
         nw.v    = in_valid;
         oreg[k] = flush ? stage_t'(0) : mux(k);
         if (flush) begin
            for (int i = 0; i < 8; i++) mdl[k][i] = '0;
         end else if (enable) begin
            if (!dir) begin
               for (int i = dep[k] - 1; i > 0; i--) mdl[k][i] = mdl[k][i-1];
               mdl[k][0] = nw;
            end else begin
               for (int i = 0; i < dep[k] - 1; i++) mdl[k][i] = mdl[k][i+1];
               mdl[k][dep[k]-1] = nw;
            end
         end
      end
   endtask

   // ---------------- driver / checker tasks ----------------
   task automatic step();
      @(posedge clk);
      if (reset) model_edge();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      stage_t ea, eb;
      ea = exp_stage(0);
      eb = exp_stage(1);
      chk({tag, " a.out"},        32'(out_a), 32'(ea.d));
      chk({tag, " a.out_valid"},  32'(ov_a),  32'(ea.v));
      chk({tag, " a.fill_count"}, 32'(fc_a),  32'(exp_cnt(0)));
      chk({tag, " b.out"},        32'(out_b), 32'(eb.d));
      chk({tag, " b.out_valid"},  32'(ov_b),  32'(eb.v));
      chk({tag, " b.fill_count"}, 32'(fc_b),  32'(exp_cnt(1)));
   endtask

   task automatic do_flush();
      flush    = 1'b1;
      enable   = 1'b1;
      in_w     = 8'hAA;
      in_valid = 1'b1;
      step();
      flush = 1'b0;
      chk("flush count", 32'(fc_a), 32'd0);
   endtask

   logic [BW-1:0] vec [8] = '{8'h6F, 8'h7E, 8'h0A, 8'h3B, 8'h2C, 8'h99, 8'h05, 8'h33};

   task automatic fill_run(input logic d, input string nm);
      int ix;
      do_flush();
      dir      = d;
      tap      = 3'd7;
      in_valid = 1'b1;
      enable   = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         in_w = (e <= 8) ? vec[e-1] : 8'h00;
         step();
         check_all(nm);
         ix = e - 8 - LAT;
         chk({nm, " seq out"}, 32'(out_a), (ix >= 0 && ix <= 7) ? 32'(vec[ix]) : 32'd0);
         chk({nm, " seq count"}, 32'(fc_a), (e < 8) ? 32'(e) : 32'd8);
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      stage_t hold_exp;
      int     hold_cnt;
      int     ix;
      model_reset();

      // reset state
      #12;
      check_all("reset");
      chk("reset out", 32'(out_a), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // fill in both directions
      fill_run(1'b0, "fill_left");
      fill_run(1'b1, "fill_right");

      // tap=2: first word after 3 edges
      do_flush();
      dir = 1'b0; tap = 3'd2; in_valid = 1'b1; enable = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         in_w = vec[e-1];
         step();
         check_all("tap2");
         ix = e - 3 - LAT;
         chk("tap2 out", 32'(out_a), (ix >= 0) ? 32'(vec[ix]) : 32'd0);
      end

      // live tap change to 0 shows the last accepted word
      enable = 1'b0;
      tap    = 3'd0;
      #1;
      check_all("live_tap");
`ifndef SHIFT_ARRAY_OUT_REG_EN
      chk("live_tap out", 32'(out_a), 32'h33);
`endif
      step();
      chk("live_tap edge out", 32'(out_a), 32'h33);

      // clamp on the 6-deep instance: tap 7 reads like tap 5
      tap = 3'd7;
      #1;
      check_all("clamp");
      step();
      check_all("clamp_edge");

      // hold for 4 edges
      tap = 3'd7; enable = 1'b1; in_valid = 1'b1;
      for (int e = 0; e < 3; e++) begin
         in_w = 8'(e + 8'h50);
         step();
         check_all("pre_hold");
      end
      hold_exp = mux(0);
      hold_cnt = exp_cnt(0);
      enable   = 1'b0;
      in_w     = 8'hEE;
      for (int e = 0; e < 4; e++) begin
         step();
         check_all("hold");
         chk("hold out", 32'(out_a), 32'(hold_exp.d));
         chk("hold count", 32'(fc_a), 32'(hold_cnt));
      end

      // flush with enable and AA on the input
      do_flush();
      check_all("flush_aa");
      chk("flush out_valid", 32'(ov_a), 32'd0);
      for (int t = 0; t < 8; t++) begin
         tap = 3'(t);
         #1;
         chk("flush stage data", 32'(out_a), 32'd0);
         chk("flush stage valid", 32'(ov_a), 32'd0);
      end

      // alternating valid tags
      dir = 1'b0; tap = 3'd7; enable = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         in_valid = e[0];
         in_w     = 8'($urandom_range(0, 255));
         step();
         check_all("valid_alt");
         if (e >= 8 + LAT) chk("valid_alt out_valid", 32'(ov_a), 32'((e - 7 - LAT) % 2));
         if (e >= 8) chk("valid_alt count", 32'(fc_a), 32'd4);
      end

      // asynchronous reset between edges with the array full
      in_valid = 1'b1;
      for (int e = 0; e < 8; e++) begin
         in_w = 8'($urandom_range(1, 255));
         step();
      end
      check_all("pre_async");
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("async out", 32'(out_a), 32'd0);
      chk("async out_valid", 32'(ov_a), 32'd0);
      chk("async count", 32'(fc_a), 32'd0);
      check_all("async");
      step();
      check_all("async_held");
      @(negedge clk);
      reset = 1'b1;
      step();
      check_all("post_release");

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         enable   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) dir = ~dir;
         flush    = ($urandom_range(0, 40) == 0);
         in_w     = 8'($urandom_range(0, 255));
         in_valid = 1'($urandom_range(0, 1));
         tap      = 3'($urandom_range(0, 7));
         step();
         check_all("random");
         if ($urandom_range(0, 3) == 0) begin
            tap = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) dir = ~dir;
            #1;
            check_all("random_live");
         end
      end
      flush = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
